// File: rtl/tcp_tx_sched_if.sv
// Bundles the new-flow, pending-flag update and TX request channels of the scheduler.
// The scheduler uses the slave modport; its environment uses the master modport.
interface tcp_tx_sched_if #(
  parameter int unsigned FLOWID_W = 6,
  parameter int unsigned FLAG_W   = 3
);
  logic                new_flow_val;
  logic [FLOWID_W-1:0] new_flow_flowid;
  logic                sched_new_flow_rdy;

  logic                sched_update_val;
  logic [FLOWID_W-1:0] sched_update_flowid;
  logic [FLAG_W-1:0]   sched_update_set;
  logic [FLAG_W-1:0]   sched_update_clr;
  logic                sched_update_deact;
  logic                sched_update_rdy;

  logic                sched_tx_req_val;
  logic [FLOWID_W-1:0] sched_tx_req_flowid;
  logic [FLAG_W-1:0]   sched_tx_req_flags;
  logic                tx_sched_req_rdy;

  modport master (
    output new_flow_val, new_flow_flowid,
    output sched_update_val, sched_update_flowid, sched_update_set,
    output sched_update_clr, sched_update_deact,
    output tx_sched_req_rdy,
    input  sched_new_flow_rdy, sched_update_rdy,
    input  sched_tx_req_val, sched_tx_req_flowid, sched_tx_req_flags
  );

  modport slave (
    input  new_flow_val, new_flow_flowid,
    input  sched_update_val, sched_update_flowid, sched_update_set,
    input  sched_update_clr, sched_update_deact,
    input  tx_sched_req_rdy,
    output sched_new_flow_rdy, sched_update_rdy,
    output sched_tx_req_val, sched_tx_req_flowid, sched_tx_req_flags
  );
endinterface

// File: rtl/tcp_tx_sched.sv
// Round-robin TCP transmit scheduler: scans a per-flow table of active/pending-work
// bits one flow per cycle and issues a request for each active flow with pending work.
module tcp_tx_sched #(
  parameter int unsigned FLOWID_W = 6,
  parameter int unsigned FLAG_W   = 3
) (
  input logic           clk,
  input logic           rst,
  tcp_tx_sched_if.slave sif
);

  localparam int unsigned NFLOWS = 32'd1 << FLOWID_W;

  typedef enum logic [0:0] {SCAN, ISSUE} state_t;

  state_t              state_q, state_d;
  logic [FLOWID_W-1:0] scan_ptr_q, scan_ptr_d;
  logic                val_q, val_d;
  logic [FLOWID_W-1:0] req_flowid_q, req_flowid_d;
  logic [FLAG_W-1:0]   req_flags_q, req_flags_d;

  logic [NFLOWS-1:0]   active_q, active_d;
  logic [FLAG_W-1:0]   flags_q [NFLOWS];
  logic [FLAG_W-1:0]   flags_d [NFLOWS];

  logic                latch_c;
  logic                upd_acc_c;

  assign sif.sched_new_flow_rdy  = 1'b1;
  assign sif.sched_update_rdy    = ~sif.new_flow_val;
  assign sif.sched_tx_req_val    = val_q;
  assign sif.sched_tx_req_flowid = req_flowid_q;
  assign sif.sched_tx_req_flags  = req_flags_q;

  // FSM state and request output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SCAN;
      scan_ptr_q   <= '0;
      val_q        <= 1'b0;
      req_flowid_q <= '0;
      req_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      scan_ptr_q   <= scan_ptr_d;
      val_q        <= val_d;
      req_flowid_q <= req_flowid_d;
      req_flags_q  <= req_flags_d;
    end
  end

  // Next-state: examine one flow per cycle in SCAN, hold the request in ISSUE
  always_comb begin
    state_d      = state_q;
    scan_ptr_d   = scan_ptr_q;
    val_d        = val_q;
    req_flowid_d = req_flowid_q;
    req_flags_d  = req_flags_q;
    latch_c      = 1'b0;
    case (state_q)
      SCAN: begin
        if (active_q[scan_ptr_q] && (flags_q[scan_ptr_q] != '0)) begin
          latch_c      = 1'b1;
          req_flowid_d = scan_ptr_q;
          req_flags_d  = flags_q[scan_ptr_q];
          val_d        = 1'b1;
          state_d      = ISSUE;
        end else begin
          scan_ptr_d = scan_ptr_q + FLOWID_W'(1);
        end
      end
      ISSUE: begin
        if (sif.tx_sched_req_rdy) begin
          val_d      = 1'b0;
          scan_ptr_d = scan_ptr_q + FLOWID_W'(1);
          state_d    = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // Flow table update; the latch clear lands before a same-cycle command so its set bits survive
  always_comb begin
    upd_acc_c = sif.sched_update_val & ~sif.new_flow_val;
    active_d  = active_q;
    for (int unsigned i = 0; i < NFLOWS; i++) begin
      flags_d[i] = flags_q[i];
      if (latch_c && (scan_ptr_q == FLOWID_W'(i))) begin
        flags_d[i] = '0;
      end
      if (upd_acc_c && (sif.sched_update_flowid == FLOWID_W'(i))) begin
        if (sif.sched_update_deact) begin
          active_d[i] = 1'b0;
          flags_d[i]  = '0;
        end else begin
          flags_d[i] = (flags_d[i] & ~sif.sched_update_clr) | sif.sched_update_set;
        end
      end
      if (sif.new_flow_val && (sif.new_flow_flowid == FLOWID_W'(i))) begin
        active_d[i] = 1'b1;
        flags_d[i]  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= '0;
      for (int unsigned i = 0; i < NFLOWS; i++) begin
        flags_q[i] <= '0;
      end
    end else begin
      active_q <= active_d;
      for (int unsigned i = 0; i < NFLOWS; i++) begin
        flags_q[i] <= flags_d[i];
      end
    end
  end

endmodule

// File: tb/tb_tcp_tx_sched.sv
// Scoreboard bench for tcp_tx_sched: stimulus pushes expected requests derived from a
// flow-table model; a negedge monitor pops and compares on every request handshake.
module tb_tcp_tx_sched;

  localparam int unsigned FW = 6;
  localparam int unsigned GW = 3;
  localparam int NF = 64;

  typedef struct packed {
    logic [FW-1:0] id;
    logic [GW-1:0] fl;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   hs_count = 0;

  req_t          exp_q[$];
  logic          mdl_act [NF];
  logic [GW-1:0] mdl_pend[NF];

  tcp_tx_sched_if #(.FLOWID_W(FW), .FLAG_W(GW)) sif();

  tcp_tx_sched #(.FLOWID_W(FW), .FLAG_W(GW)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: stability while stalled, scoreboard compare on handshake
  logic          prev_stall = 1'b0;
  logic [FW-1:0] prev_id;
  logic [GW-1:0] prev_fl;
  req_t          mon_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_val", int'(sif.sched_tx_req_val), 1);
        chk("hold_flowid", int'(sif.sched_tx_req_flowid), int'(prev_id));
        chk("hold_flags", int'(sif.sched_tx_req_flags), int'(prev_fl));
      end
      if (sif.sched_tx_req_val && sif.tx_sched_req_rdy) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req got flowid=%0d flags=%0d exp none", sif.sched_tx_req_flowid,
                   sif.sched_tx_req_flags);
        end else begin
          mon_e = exp_q.pop_front();
          chk("req_flowid", int'(sif.sched_tx_req_flowid), int'(mon_e.id));
          chk("req_flags", int'(sif.sched_tx_req_flags), int'(mon_e.fl));
        end
      end
      prev_stall = sif.sched_tx_req_val && !sif.tx_sched_req_rdy;
      prev_id    = sif.sched_tx_req_flowid;
      prev_fl    = sif.sched_tx_req_flags;
    end
  end

  function automatic void mdl_reset();
    for (int i = 0; i < NF; i++) begin
      mdl_act[i]  = 1'b0;
      mdl_pend[i] = '0;
    end
  endfunction

  function automatic void mdl_update(input int id, input logic [GW-1:0] set, input logic [GW-1:0] clr,
                                     input logic deact);
    if (deact) begin
      mdl_act[id]  = 1'b0;
      mdl_pend[id] = '0;
    end else begin
      mdl_pend[id] = (mdl_pend[id] & ~clr) | set;
    end
  endfunction

  function automatic void push_exp(input int id, input logic [GW-1:0] fl);
    req_t e;
    e.id = FW'(id);
    e.fl = fl;
    exp_q.push_back(e);
  endfunction

  // Service order after a handshake on anchor: every eligible flow, circularly from anchor+1
  function automatic void push_round(input int anchor);
    for (int i = 1; i <= NF; i++) begin
      int f;
      f = (anchor + i) % NF;
      if (mdl_act[f] && mdl_pend[f] != '0) begin
        push_exp(f, mdl_pend[f]);
        mdl_pend[f] = '0;
      end
    end
  endfunction

  task automatic do_new(input int id);
    sif.new_flow_val    = 1'b1;
    sif.new_flow_flowid = FW'(id);
    tick();
    sif.new_flow_val    = 1'b0;
    mdl_act[id]  = 1'b1;
    mdl_pend[id] = '0;
  endtask

  task automatic do_upd(input int id, input logic [GW-1:0] set, input logic [GW-1:0] clr,
                        input logic deact);
    sif.sched_update_val    = 1'b1;
    sif.sched_update_flowid = FW'(id);
    sif.sched_update_set    = set;
    sif.sched_update_clr    = clr;
    sif.sched_update_deact  = deact;
    tick();
    sif.sched_update_val    = 1'b0;
    sif.sched_update_deact  = 1'b0;
    mdl_update(id, set, clr, deact);
  endtask

  // new_flow and an update in the same cycle: the update must wait one cycle
  task automatic do_combo(input int id, input int id2, input logic [GW-1:0] set,
                          input logic [GW-1:0] clr);
    sif.new_flow_val        = 1'b1;
    sif.new_flow_flowid     = FW'(id);
    sif.sched_update_val    = 1'b1;
    sif.sched_update_flowid = FW'(id2);
    sif.sched_update_set    = set;
    sif.sched_update_clr    = clr;
    sif.sched_update_deact  = 1'b0;
    #1;
    chk("upd_rdy_blocked", int'(sif.sched_update_rdy), 0);
    @(posedge clk);
    #1;
    sif.new_flow_val = 1'b0;
    mdl_act[id]  = 1'b1;
    mdl_pend[id] = '0;
    tick();
    sif.sched_update_val = 1'b0;
    mdl_update(id2, set, clr, 1'b0);
  endtask

  task automatic wait_val();
    int n = 0;
    while (!sif.sched_tx_req_val && n < 100) begin
      tick();
      n++;
    end
    chk("val_within_bound", int'(sif.sched_tx_req_val), 1);
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_count < target && n < 200) begin
      tick();
      n++;
    end
    chk("hs_within_bound", int'(hs_count >= target), 1);
  endtask

  task automatic drain(input bit rand_rdy, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      sif.tx_sched_req_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
    sif.tx_sched_req_rdy = 1'b1;
    tick();
  endtask

  task automatic idle_check(input int n);
    int h0;
    h0 = hs_count;
    sif.tx_sched_req_rdy = 1'b1;
    repeat (n) tick();
    chk("no_extra_req", hs_count - h0, 0);
  endtask

  // Park the scheduler in ISSUE on anchor with rdy low so stall-time updates are order-free
  task automatic begin_round(input int a, input logic [GW-1:0] f);
    sif.tx_sched_req_rdy = 1'b0;
    do_new(a);
    do_upd(a, f, '0, 1'b0);
    push_exp(a, f);
    mdl_pend[a] = '0;
    wait_val();
  endtask

  task automatic rand_stall_ops(input int n);
    for (int k = 0; k < n; k++) begin
      int kind, id, id2;
      kind = int'($urandom_range(0, 9));
      id   = int'($urandom_range(0, NF - 1));
      id2  = int'($urandom_range(0, NF - 1));
      if (kind < 6) begin
        do_upd(id, GW'($urandom), GW'($urandom), ($urandom_range(0, 7) == 0));
      end else if (kind < 8) begin
        do_new(id);
      end else begin
        do_combo(id, id2, GW'($urandom), GW'($urandom));
      end
    end
  endtask

  initial begin
    sif.new_flow_val        = 1'b0;
    sif.new_flow_flowid     = '0;
    sif.sched_update_val    = 1'b0;
    sif.sched_update_flowid = '0;
    sif.sched_update_set    = '0;
    sif.sched_update_clr    = '0;
    sif.sched_update_deact  = 1'b0;
    sif.tx_sched_req_rdy    = 1'b1;
    mdl_reset();

    // Reset state
    repeat (3) tick();
    chk("rst_new_flow_rdy", int'(sif.sched_new_flow_rdy), 1);
    chk("rst_val", int'(sif.sched_tx_req_val), 0);
    chk("rst_flowid", int'(sif.sched_tx_req_flowid), 0);
    chk("rst_flags", int'(sif.sched_tx_req_flags), 0);
    chk("rst_upd_rdy", int'(sif.sched_update_rdy), 1);

    // Update on flow 7 in the very cycle the scan (pointer counts up from 0) latches it
    rst = 1'b0;
    do_new(7);
    do_upd(7, 3'b100, 3'b000, 1'b0);
    repeat (5) tick();
    do_upd(7, 3'b010, 3'b010, 1'b0);
    push_exp(7, 3'b100);
    push_exp(7, 3'b010);
    mdl_pend[7] = '0;
    drain(1'b0, 200);

    // Single flow, then no further requests
    do_new(5);
    do_upd(5, 3'b001, 3'b000, 1'b0);
    push_exp(5, 3'b001);
    mdl_pend[5] = '0;
    drain(1'b0, 70);
    idle_check(80);

    // Long stall on flow 3; the scan resumes at 4
    begin_round(3, 3'b010);
    do_new(2);
    do_upd(2, 3'b100, 3'b000, 1'b0);
    do_new(4);
    do_upd(4, 3'b001, 3'b000, 1'b0);
    repeat (6) tick();
    push_round(3);
    drain(1'b0, 300);

    // Two flows re-set after every service alternate
    begin_round(2, 3'b001);
    do_new(9);
    do_upd(9, 3'b001, 3'b000, 1'b0);
    mdl_pend[9] = '0;
    push_exp(9, 3'b001);
    push_exp(2, 3'b001);
    push_exp(9, 3'b001);
    push_exp(2, 3'b001);
    push_exp(9, 3'b001);
    begin
      int h0;
      h0 = hs_count;
      sif.tx_sched_req_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
        wait_hs(h0 + k + 1);
        do_upd((k % 2 == 0) ? 2 : 9, 3'b001, 3'b000, 1'b0);
        mdl_pend[(k % 2 == 0) ? 2 : 9] = '0;
      end
    end
    drain(1'b0, 400);

    // Inactive and deactivated flow 12 never scheduled
    begin_round(20, 3'b011);
    do_upd(12, 3'b111, 3'b000, 1'b0);
    do_new(12);
    do_upd(12, 3'b101, 3'b000, 1'b0);
    do_upd(12, 3'b000, 3'b000, 1'b1);
    do_upd(20, 3'b000, 3'b000, 1'b1);
    push_round(20);
    drain(1'b0, 300);
    idle_check(80);

    // new_flow blocks a same-cycle update, which is then taken on the next cycle
    begin_round(30, 3'b001);
    do_combo(31, 31, 3'b101, 3'b000);
    push_round(30);
    drain(1'b1, 400);

    // Randomized rounds against the flow-table model
    for (int r = 0; r < 20; r++) begin
      int a;
      a = int'($urandom_range(0, NF - 1));
      begin_round(a, GW'($urandom_range(1, 7)));
      rand_stall_ops(int'($urandom_range(2, 10)));
      push_round(a);
      drain(1'b1, 3000);
    end

    // Reset while in ISSUE discards the request and clears the table
    begin_round(40, 3'b110);
    do_new(41);
    do_upd(41, 3'b001, 3'b000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    mdl_reset();
    chk("mid_rst_val", int'(sif.sched_tx_req_val), 0);
    chk("mid_rst_flowid", int'(sif.sched_tx_req_flowid), 0);
    chk("mid_rst_flags", int'(sif.sched_tx_req_flags), 0);
    do_upd(41, 3'b111, 3'b000, 1'b0);
    idle_check(80);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
